// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;

  localparam int MAX_WORDS_DEF = 1024;
  localparam int BYTE_W        = 8;
  localparam int HDR_W         = 2 * BYTE_W;
  localparam int CSUM_W        = BYTE_W;
endpackage

// File: rtl/imem_word_asm.sv
// Packs MSB-first bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
module imem_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        xfer,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        last_byte,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] sr;

  assign last_byte = xfer && (lane == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= 2'd0;
      sr         <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
        sr   <= 24'd0;
      end else if (xfer) begin
        lane <= lane + 2'd1;
        sr   <= {sr[15:0], byte_in};
        if (lane == 2'd3) begin
          word       <= {sr, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte stream, writes instruction words and checks an XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  state_t              state, state_nxt;
  logic [BYTE_W-1:0]   hdr_hi_q;
  logic [HDR_W-1:0]    n_words, hdr_n;
  logic [CSUM_W-1:0]   csum;
  logic [29:0]         wcnt;
  logic                xfer, restart, last_byte, final_byte, word_valid;
  logic [1:0]          lane;
  logic [31:0]         word;

  assign xfer    = byte_valid && byte_ready;
  assign restart = start && (state == DONE || state == ERR);
  assign hdr_n   = {hdr_hi_q, byte_in};

  // The previous word is always written before the next one completes, so wcnt equals the index of the completing word.
  assign final_byte = last_byte && (wcnt == 30'(n_words) - 30'd1);

  imem_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .xfer       (xfer && state == DATA),
    .byte_in    (byte_in),
    .lane       (lane),
    .last_byte  (last_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_HI: if (xfer) state_nxt = HDR_LO;
      HDR_LO: if (xfer) begin
        if (hdr_n == '0)                 state_nxt = CHK;
        else if (int'(hdr_n) > MAX_WORDS) state_nxt = ERR;
        else                             state_nxt = DATA;
      end
      DATA:   if (final_byte) state_nxt = CHK;
      CHK:    if (xfer) state_nxt = (byte_in == csum) ? DONE : ERR;
      DONE, ERR: if (start) state_nxt = HDR_HI;
      default: state_nxt = HDR_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HDR_HI;
      hdr_hi_q <= '0;
      n_words  <= '0;
      csum     <= '0;
      wcnt     <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && state == HDR_HI) hdr_hi_q <= byte_in;
      if (xfer && state == HDR_LO) n_words  <= hdr_n;
      if (restart)
        csum <= '0;
      else if (xfer && (state == HDR_HI || state == HDR_LO || state == DATA))
        csum <= csum ^ byte_in;
      if (restart)      wcnt <= '0;
      else if (imem_we) wcnt <= wcnt + 30'd1;
    end
  end

  assign byte_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CHK);
  assign imem_we    = word_valid;
  assign imem_wdata = word;
  assign imem_addr  = {wcnt, 2'b00};
  assign cpu_hold   = (state != DONE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, oversize header, empty load, gaps and reset.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, imem_we, cpu_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // imem_we is a single-cycle strobe, so each negedge sample logs one write
  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h, input logic r);
    chk({tag, ".done"},       32'(done),       32'(d));
    chk({tag, ".error"},      32'(error),      32'(e));
    chk({tag, ".cpu_hold"},   32'(cpu_hold),   32'(h));
    chk({tag, ".byte_ready"}, 32'(byte_ready), 32'(r));
  endtask

  initial begin
    logic [7:0] s1 [11];
    s1 = '{8'h00, 8'h02, 8'h80, 8'h00, 8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8E};

    // reset values
    #12;
    chk("rst.we",    32'(imem_we), 32'd0);
    chk("rst.addr",  imem_addr,    32'd0);
    chk("rst.wdata", imem_wdata,   32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // good load, back-to-back; XOR of header+data bytes is 8E
    foreach (s1[i]) send(s1[i], 0);
    @(negedge clk);
    chk("good.nwr",   32'(wa.size()), 32'd2);
    chk("good.a0",    wa[0], 32'h0);
    chk("good.d0",    wd[0], 32'h8000060A);
    chk("good.a1",    wa[1], 32'h4);
    chk("good.d1",    wd[1], 32'h0);
    chk_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
    // byte_valid in DONE is ignored
    send(8'h55, 0);
    @(negedge clk);
    chk_status("done_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_idle.nwr", 32'(wa.size()), 32'd2);

    // restart from DONE, same stream with bad checksum
    wa.delete(); wd.delete();
    pulse_start();
    chk("restart.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart.done",     32'(done),     32'd0);
    for (int i = 0; i < 10; i++) send(s1[i], 0);
    send(8'h8D, 0);
    @(negedge clk);
    chk("bad.nwr", 32'(wa.size()), 32'd2);
    chk("bad.a0",  wa[0], 32'h0);
    chk("bad.d0",  wd[0], 32'h8000060A);
    chk("bad.a1",  wa[1], 32'h4);
    chk_status("bad", 1'b0, 1'b1, 1'b1, 1'b0);

    // oversize header 0x0401 = 1025 words
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h04, 0);
    chk("big.mid_err", 32'(error), 32'd0);
    send(8'h01, 0);
    chk_status("big", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("big.nwr", 32'(wa.size()), 32'd0);

    // empty load
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty.nwr", 32'(wa.size()), 32'd0);

    // gapped load, then reset mid-DATA
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h00, $urandom_range(5, 0));
    send(8'h02, $urandom_range(5, 0));
    send(8'h11, $urandom_range(5, 0));
    send(8'h22, $urandom_range(5, 0));
    send(8'h33, $urandom_range(5, 0));
    send(8'h44, $urandom_range(5, 0));
    send(8'h55, $urandom_range(5, 0));
    send(8'h66, $urandom_range(5, 0));
    chk("gap.nwr", 32'(wa.size()), 32'd1);
    chk("gap.d0",  wd[0], 32'h11223344);
    chk("gap.a0",  wa[0], 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("midrst.we",    32'(imem_we), 32'd0);
    chk("midrst.addr",  imem_addr,    32'd0);
    chk("midrst.wdata", imem_wdata,   32'd0);
    chk_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // fresh 1-word load; checksum 01^DE^AD^BE^EF = 23
    wa.delete(); wd.delete();
    send(8'h00, 1);
    send(8'h01, 2);
    send(8'hDE, 0);
    send(8'hAD, 3);
    send(8'hBE, 0);
    send(8'hEF, 5);
    send(8'h23, 1);
    @(negedge clk);
    chk("fresh.nwr", 32'(wa.size()), 32'd1);
    chk("fresh.a0",  wa[0], 32'h0);
    chk("fresh.d0",  wd[0], 32'hDEADBEEF);
    chk_status("fresh", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
